// File: rtl/mod_cfg_pkg.sv
// Shared types and constants for the QAM modulator configuration sequencer.
package mod_cfg_pkg;

  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baud_e;

  typedef struct packed {
    logic        mod_type;       // 0 = QPSK, 1 = 16QAM
    logic [1:0]  baud_rate;
    logic        filter_enable;
    logic [15:0] carrier_freq;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    mod_type:      1'b0,
    baud_rate:     BAUD_2400,
    filter_enable: 1'b1,
    carrier_freq:  16'h0000
  };

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PEND,
    ST_FLUSH,
    ST_SETTLE
  } state_t;

  // True when two configs differ in the carrier setting and nothing else.
  function automatic logic cfg_carrier_only_diff(cfg_t a, cfg_t b);
    return (a.carrier_freq != b.carrier_freq) &&
           (a.mod_type == b.mod_type) &&
           (a.baud_rate == b.baud_rate) &&
           (a.filter_enable == b.filter_enable);
  endfunction

endpackage

// File: rtl/mod_cfg_ctrl_if.sv
// Configuration request handshake between a settings source and mod_cfg_ctrl.
interface mod_cfg_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_mod_type;
  logic [1:0]  cfg_baud_rate;
  logic        cfg_filter_enable;
  logic [15:0] cfg_carrier_freq;

  modport master (
    output cfg_valid, cfg_mod_type, cfg_baud_rate, cfg_filter_enable, cfg_carrier_freq,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mod_type, cfg_baud_rate, cfg_filter_enable, cfg_carrier_freq,
    output cfg_ready
  );
endinterface

// File: rtl/mod_cfg_strobe_wait.sv
// Symbol-strobe waiter: gap counter that turns either a real strobe or a
// STROBE_TIMEOUT-cycle gap into a single event pulse. Cleared while disabled.
module mod_cfg_strobe_wait #(
  parameter int unsigned STROBE_TIMEOUT = 8192
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic strobe_i,
  output logic event_o,
  output logic timeout_o
);

  localparam int unsigned CW = (STROBE_TIMEOUT > 1) ? $clog2(STROBE_TIMEOUT) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(STROBE_TIMEOUT - 1);

  logic [CW-1:0] gap_q, gap_d;
  logic          at_last;

  // Event/timeout decode and gap counter next value.
  always_comb begin
    at_last   = (gap_q == GAP_LAST);
    event_o   = en_i & (strobe_i | at_last);
    timeout_o = en_i & ~strobe_i & at_last;
    gap_d     = gap_q + CW'(1);
    if (!en_i || event_o) gap_d = '0;
  end

  // Gap counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end

endmodule

// File: rtl/mod_cfg_ctrl.sv
// Run-time configuration sequencer for the QAM modulator datapath.
// Optional feature macro: MOD_CFG_CARRIER_HITLESS_EN (carrier-only changes
// are applied on a symbol boundary without flush or mute).
module mod_cfg_ctrl
  import mod_cfg_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES   = 8,
  parameter int unsigned SETTLE_SYMBOLS = 16,
  parameter int unsigned STROBE_TIMEOUT = 8192
) (
  input  logic                clk,
  input  logic                rst_n,
  mod_cfg_ctrl_if.slave       cfg,
  input  logic                symbol_strobe,
  output logic                mod_type,
  output logic [1:0]          baud_rate,
  output logic                filter_enable,
  output logic [15:0]         carrier_freq_set,
  output logic                dp_rst_n,
  input  logic [31:0]         mod_iq_in,
  output logic [31:0]         mod_iq_out,
  output logic                tx_active,
  output logic                busy,
  output logic                timeout_flag,
  output logic [7:0]          reconfig_cnt
);

  localparam logic [7:0] FLUSH_LAST  = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_SYMBOLS - 1);

  state_t      state_q, state_d;
  cfg_t        applied_q, applied_d;
  cfg_t        shadow_q, shadow_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic [7:0]  reconfig_cnt_q, reconfig_cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] iq_q, iq_d;

  cfg_t        cfg_in;
  logic        wait_en, wait_event, wait_timeout;
  logic        hitless;

  assign cfg_in = '{
    mod_type:      cfg.cfg_mod_type,
    baud_rate:     cfg.cfg_baud_rate,
    filter_enable: cfg.cfg_filter_enable,
    carrier_freq:  cfg.cfg_carrier_freq
  };

  assign wait_en = (state_q == ST_PEND) || (state_q == ST_SETTLE);

`ifdef MOD_CFG_CARRIER_HITLESS_EN
  assign hitless = cfg_carrier_only_diff(shadow_q, applied_q);
`else
  assign hitless = 1'b0;
`endif

  mod_cfg_strobe_wait #(
    .STROBE_TIMEOUT (STROBE_TIMEOUT)
  ) u_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (wait_en),
    .strobe_i  (symbol_strobe),
    .event_o   (wait_event),
    .timeout_o (wait_timeout)
  );

  // Next-state and datapath control; IQ stays live in PEND since the old config is still valid.
  always_comb begin
    state_d        = state_q;
    applied_d      = applied_q;
    shadow_d       = shadow_q;
    flush_cnt_d    = flush_cnt_q;
    settle_cnt_d   = settle_cnt_q;
    reconfig_cnt_d = reconfig_cnt_q;
    timeout_d      = timeout_q | wait_timeout;
    iq_d           = ((state_q == ST_RUN) || (state_q == ST_PEND)) ? mod_iq_in : '0;

    unique case (state_q)
      ST_RUN: begin
        if (cfg.cfg_valid) begin
          shadow_d = cfg_in;
          if (cfg_in != applied_q) state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (wait_event) begin
          applied_d = shadow_q;
          if (reconfig_cnt_q != 8'hFF) reconfig_cnt_d = reconfig_cnt_q + 8'd1;
          if (hitless) begin
            state_d = ST_RUN;
          end else begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (wait_event) begin
          if (settle_cnt_q == SETTLE_LAST) state_d = ST_RUN;
          else                             settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  // State and register bank; reset restarts a flush with default config.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_FLUSH;
      applied_q      <= CFG_DEFAULT;
      shadow_q       <= CFG_DEFAULT;
      flush_cnt_q    <= '0;
      settle_cnt_q   <= '0;
      reconfig_cnt_q <= '0;
      timeout_q      <= 1'b0;
      iq_q           <= '0;
    end else begin
      state_q        <= state_d;
      applied_q      <= applied_d;
      shadow_q       <= shadow_d;
      flush_cnt_q    <= flush_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      reconfig_cnt_q <= reconfig_cnt_d;
      timeout_q      <= timeout_d;
      iq_q           <= iq_d;
    end
  end

  assign cfg.cfg_ready      = (state_q == ST_RUN);
  assign tx_active          = (state_q == ST_RUN);
  assign busy               = (state_q != ST_RUN);
  assign dp_rst_n           = (state_q != ST_FLUSH);
  assign mod_type           = applied_q.mod_type;
  assign baud_rate          = applied_q.baud_rate;
  assign filter_enable      = applied_q.filter_enable;
  assign carrier_freq_set   = applied_q.carrier_freq;
  assign mod_iq_out         = iq_q;
  assign timeout_flag       = timeout_q;
  assign reconfig_cnt       = reconfig_cnt_q;

endmodule

// File: tb/tb_mod_cfg_ctrl.sv
// Self-checking bench for mod_cfg_ctrl: directed steps with scoreboards for
// applied configuration and gated IQ output. Honors MOD_CFG_CARRIER_HITLESS_EN.
module tb_mod_cfg_ctrl;
  import mod_cfg_pkg::*;

  localparam int unsigned P = 20;  // symbol strobe period used in settle phases

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        symbol_strobe = 1'b0;
  logic [31:0] mod_iq_in = '0;
  logic        mod_type, filter_enable, dp_rst_n, tx_active, busy, timeout_flag;
  logic [1:0]  baud_rate;
  logic [15:0] carrier_freq_set;
  logic [31:0] mod_iq_out;
  logic [7:0]  reconfig_cnt;
  logic [19:0] applied_obs;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   iq_pass = 1'b0;
  logic [31:0] iq_sb[$];
  cfg_t        cfg_sb[$];

  mod_cfg_ctrl_if cfg_if();

  mod_cfg_ctrl #(
    .FLUSH_CYCLES   (8),
    .SETTLE_SYMBOLS (16),
    .STROBE_TIMEOUT (8192)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg              (cfg_if),
    .symbol_strobe    (symbol_strobe),
    .mod_type         (mod_type),
    .baud_rate        (baud_rate),
    .filter_enable    (filter_enable),
    .carrier_freq_set (carrier_freq_set),
    .dp_rst_n         (dp_rst_n),
    .mod_iq_in        (mod_iq_in),
    .mod_iq_out       (mod_iq_out),
    .tx_active        (tx_active),
    .busy             (busy),
    .timeout_flag     (timeout_flag),
    .reconfig_cnt     (reconfig_cnt)
  );

  assign applied_obs = {mod_type, baud_rate, filter_enable, carrier_freq_set};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: push expected IQ, advance, compare registered output.
  task automatic step();
    logic [31:0] exp_iq;
    iq_sb.push_back(iq_pass ? mod_iq_in : 32'd0);
    @(posedge clk);
    #1;
    if (iq_sb.size() != 0) begin
      exp_iq = iq_sb.pop_front();
      chk("iq_out", mod_iq_out, exp_iq);
    end
    mod_iq_in = $urandom;
  endtask

  task automatic strobe_after(input int n);
    for (int i = 0; i < n - 1; i++) step();
    symbol_strobe = 1'b1;
    step();
    symbol_strobe = 1'b0;
  endtask

  task automatic drive_cfg(input cfg_t c);
    cfg_if.cfg_mod_type      = c.mod_type;
    cfg_if.cfg_baud_rate     = c.baud_rate;
    cfg_if.cfg_filter_enable = c.filter_enable;
    cfg_if.cfg_carrier_freq  = c.carrier_freq;
  endtask

  task automatic request(input cfg_t c, input bit differs);
    drive_cfg(c);
    cfg_if.cfg_valid = 1'b1;
    chk("cfg_ready_run", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    cfg_if.cfg_valid = 1'b0;
    if (differs) begin
      cfg_sb.push_back(c);
      chk("pend_busy", 32'(busy), 32'd1);
      chk("pend_dp_rst_n", 32'(dp_rst_n), 32'd1);
      chk("pend_cfg_ready", 32'(cfg_if.cfg_ready), 32'd0);
    end else begin
      chk("same_tx_active", 32'(tx_active), 32'd1);
    end
  endtask

  task automatic check_applied(input string tag);
    cfg_t e;
    chk("cfg_sb_level", 32'(cfg_sb.size()), 32'd1);
    if (cfg_sb.size() != 0) begin
      e = cfg_sb.pop_front();
      chk(tag, 32'(applied_obs), 32'(e));
    end
  endtask

  // Called on the first FLUSH cycle; strobe_at injects a strobe that must be ignored.
  task automatic check_flush(input int strobe_at);
    for (int i = 0; i < 8; i++) begin
      chk("flush_dp_rst_n", 32'(dp_rst_n), 32'd0);
      if (i == strobe_at) symbol_strobe = 1'b1;
      step();
      symbol_strobe = 1'b0;
    end
    chk("flush_release", 32'(dp_rst_n), 32'd1);
    chk("settle_busy", 32'(busy), 32'd1);
  endtask

  task automatic settle(input int period);
    for (int k = 1; k <= 16; k++) begin
      strobe_after(period);
      chk("settle_tx_active", 32'(tx_active), 32'(k == 16));
    end
    iq_pass = 1'b1;
  endtask

  task automatic full_reconfig(input cfg_t c, input int period);
    request(c, 1'b1);
    strobe_after(period);
    iq_pass = 1'b0;
    check_applied("apply_cfg");
    check_flush(-1);
    settle(period);
  endtask

  initial begin
    cfg_t c1, c_other, c2, c3, c4, ca, cb;
    c1      = '{mod_type: 1'b1, baud_rate: BAUD_19200, filter_enable: 1'b1, carrier_freq: 16'h1234};
    c_other = '{mod_type: 1'b0, baud_rate: BAUD_9600,  filter_enable: 1'b0, carrier_freq: 16'hBEEF};
    c2      = '{mod_type: 1'b0, baud_rate: BAUD_4800,  filter_enable: 1'b0, carrier_freq: 16'h00AA};
    c4      = '{mod_type: 1'b1, baud_rate: BAUD_9600,  filter_enable: 1'b0, carrier_freq: 16'h5555};
    ca      = '{mod_type: 1'b1, baud_rate: BAUD_9600,  filter_enable: 1'b1, carrier_freq: 16'h0100};
    cb      = '{mod_type: 1'b0, baud_rate: BAUD_2400,  filter_enable: 1'b0, carrier_freq: 16'h0200};
    c3 = c2;
    c3.carrier_freq = 16'h0800;

    cfg_if.cfg_valid = 1'b0;
    drive_cfg(c_other);

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_dp_rst_n", 32'(dp_rst_n), 32'd0);
    chk("rst_tx_active", 32'(tx_active), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 32'd0);
    chk("rst_timeout", 32'(timeout_flag), 32'd0);
    chk("rst_reconfig", 32'(reconfig_cnt), 32'd0);
    chk("rst_applied", 32'(applied_obs), 32'(CFG_DEFAULT));
    rst_n = 1'b1;

    // Initial flush (strobe in last flush cycle ignored) and settle
    check_flush(7);
    settle(P);
    chk("init_reconfig", 32'(reconfig_cnt), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    repeat (5) step();

    // Full reconfiguration, plus a request offered outside RUN
    request(c1, 1'b1);
    chk("pend_applied_old", 32'(applied_obs), 32'(CFG_DEFAULT));
    drive_cfg(c_other);
    cfg_if.cfg_valid = 1'b1;
    chk("pend_ignores_valid", 32'(cfg_if.cfg_ready), 32'd0);
    step();
    cfg_if.cfg_valid = 1'b0;
    strobe_after(10);
    iq_pass = 1'b0;
    check_applied("apply_c1");
    chk("c1_reconfig", 32'(reconfig_cnt), 32'd1);
    check_flush(-1);
    settle(P);

    // Identical request is dropped
    request(c1, 1'b0);
    repeat (4) step();
    chk("same_reconfig", 32'(reconfig_cnt), 32'd1);
    chk("same_applied", 32'(applied_obs), 32'(c1));

    // Strobe timeout in PEND
    request(c2, 1'b1);
    repeat (8191) step();
    chk("to_still_pend", 32'(dp_rst_n), 32'd1);
    chk("to_busy", 32'(busy), 32'd1);
    chk("to_flag_clear", 32'(timeout_flag), 32'd0);
    step();
    iq_pass = 1'b0;
    chk("to_flush", 32'(dp_rst_n), 32'd0);
    chk("to_flag_set", 32'(timeout_flag), 32'd1);
    check_applied("apply_c2");
    chk("c2_reconfig", 32'(reconfig_cnt), 32'd2);
    check_flush(-1);
    settle(P);
    chk("to_flag_sticky", 32'(timeout_flag), 32'd1);

    // Carrier-only change
    request(c3, 1'b1);
    strobe_after(10);
`ifdef MOD_CFG_CARRIER_HITLESS_EN
    check_applied("hitless_apply");
    chk("hitless_dp_rst_n", 32'(dp_rst_n), 32'd1);
    chk("hitless_tx_active", 32'(tx_active), 32'd1);
    chk("hitless_reconfig", 32'(reconfig_cnt), 32'd3);
    repeat (4) step();
`else
    iq_pass = 1'b0;
    check_applied("carrier_apply");
    chk("carrier_reconfig", 32'(reconfig_cnt), 32'd3);
    check_flush(-1);
    settle(P);
`endif

    // Reset during SETTLE
    request(c4, 1'b1);
    strobe_after(10);
    iq_pass = 1'b0;
    check_applied("apply_c4");
    check_flush(-1);
    repeat (3) strobe_after(P);
    chk("mid_settle_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2_applied", 32'(applied_obs), 32'(CFG_DEFAULT));
    chk("rst2_reconfig", 32'(reconfig_cnt), 32'd0);
    chk("rst2_timeout", 32'(timeout_flag), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd1);
    check_flush(-1);
    settle(P);
    chk("rst2_run_applied", 32'(applied_obs), 32'(CFG_DEFAULT));
    chk("rst2_run_reconfig", 32'(reconfig_cnt), 32'd0);

    // reconfig_cnt saturation
    for (int n = 1; n <= 256; n++) begin
      full_reconfig((n % 2 == 1) ? ca : cb, 2);
      if (n == 1)   chk("sat_first", 32'(reconfig_cnt), 32'd1);
      if (n == 255) chk("sat_reach", 32'(reconfig_cnt), 32'd255);
    end
    chk("sat_hold", 32'(reconfig_cnt), 32'd255);
    chk("cfg_sb_drained", 32'(cfg_sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
